dpi_sample_queue: RTL and testbench
===================================

# dpi_sample_queue

Buffering stage directly upstream of the testbench DPI call sites. Captures sample words from the design under simulation (`childmod` / `sc_top` side) with a free-running cycle timestamp. Holds them in a small first-word-fall-through FIFO until the testbench drains them toward `sample_dpi` / `sample2`. Counts samples lost to overflow so the C side can detect gaps.

## Interface
Parameters:
- `DATA_W`, 32, sample word width.
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `TS_W`, 16, timestamp width.

Ports (`AW` = log2(DEPTH)):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `in_valid`  in  1  producer has a sample this cycle.
- `in_data`  in  DATA_W  sample word.
- `in_ready`  out  1  queue can accept (= not full).
- `out_valid`  out  1  head entry available.
- `out_data`  out  DATA_W  head sample word.
- `out_ts`  out  TS_W  timestamp captured with head word.
- `out_ready`  in  1  consumer takes head this cycle.
- `level`  out  AW+1  current occupancy, 0..DEPTH.
- `drop_cnt`  out  16  samples rejected while full; saturating.

## Operation
- Timestamp counter `ts`: increments by 1 every `clk` edge, wraps modulo 2^TS_W, and is 0 in the first cycle after reset release.
- Push: when `in_valid && in_ready`, store {`ts`, `in_data`} at the write pointer, then advance the write pointer.
- Drop: when `in_valid && !in_ready`, nothing is stored and `drop_cnt` increments. `drop_cnt` saturates at 0xFFFF and does not wrap.
- Pop: when `out_valid && out_ready`, advance the read pointer.
- `in_ready` = `level != DEPTH`. It depends only on current occupancy, never on a same-cycle pop. A sample offered while full is dropped even if a pop occurs in the same cycle.
- `out_valid` = `level != 0`. `out_data`/`out_ts` are driven combinationally from the head entry. Their value is don't-care when `out_valid`=0; the bench must not check them in that case.
- Simultaneous push and pop with 0 < level < DEPTH: both occur and `level` is unchanged.
- Pointers are AW bits and wrap naturally. `level` is kept as an explicit counter of AW+1 bits.
- `out_ready` asserted while empty has no effect. Producer and consumer need not hold `valid` / `ready` stable.

## Timing
- Reset (async assert, synchronous-style release on `clk`) forces:
  - `level`=0, `out_valid`=0, `in_ready`=1, `drop_cnt`=0, `ts`=0, both pointers 0.
  - Storage contents need not be cleared.
- Asserting reset mid-operation flushes all entries immediately. Entries in flight are lost and are not counted as drops.
- Latency: a sample accepted at edge N is presented with `out_valid`=1 in the cycle after edge N, i.e. one cycle empty-to-valid. There is no fall-through in the accept cycle itself.
- `level`, `in_ready`, `out_valid` and `drop_cnt` are all updated on the same edge as the push/pop/drop that causes the change.
- The captured `out_ts` equals the `ts` value in the cycle `in_valid && in_ready` was sampled high.

## Test plan
- **Reset values:** hold `rst`=1 for 3 cycles then release → `in_ready`=1, `out_valid`=0, `level`=0, `drop_cnt`=0. The first accepted sample at the first post-reset edge carries `out_ts`=0.
- **Ordering and timestamps:** push 0xA0..0xA4 on 5 consecutive cycles with `out_ready`=0, then drain → exact order 0xA0..0xA4. `out_ts` values are consecutive, and `level` peaks at 5 and returns to 0.
- **Overflow (DEPTH=8):** push 11 words with `out_ready`=0 → `in_ready` falls after the 8th accept, `level`=8, `drop_cnt`=3. Draining yields only the first 8 words.
- **Full with simultaneous pop:** at `level`=8 assert `in_valid` and `out_ready` together for one cycle → `drop_cnt` +1, `level`=7, and the offered word never appears.
- **Streaming wrap:** 40 cycles with `in_valid`=`out_ready`=1 and incrementing data → `level` stays at 1 after the first cycle, `drop_cnt`=0, and all 40 words emerge in order across multiple pointer wraps.
- **Reset mid-operation:** fill to `level`=5, assert `rst` asynchronously between edges → `out_valid`=0 and `level`=0 immediately. After release, a new word 0x55 is the first one out.

Source files
------------

// File: rtl/dpi_sample_queue_if.sv
// Producer/consumer handshake bundle for dpi_sample_queue.
// The slave side is the queue; the master side is the producer plus the drain logic.
interface dpi_sample_queue_if #(
  parameter int DATA_W = 32,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8
);
  localparam int AW = $clog2(DEPTH);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_ts;
  logic              out_ready;
  logic [AW:0]       level;
  logic [15:0]       drop_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ts, level, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ts, level, drop_cnt
  );
endinterface

// File: rtl/dpi_sample_queue.sv
// Timestamped first-word-fall-through sample FIFO feeding the DPI call sites.
// Samples offered while full are dropped and counted in a saturating counter.
module dpi_sample_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16
) (
  input logic            clk,
  input logic            rst,
  dpi_sample_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [15:0]   DROP_MAX   = 16'hFFFF;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level_q;
  logic [15:0]     drop_q;
  logic [TS_W-1:0] ts;

  logic full, empty, push, pop, drop;

  // Readiness looks only at current occupancy, so a same-cycle pop never frees a slot.
  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);
  assign push  = bus.in_valid && !full;
  assign drop  = bus.in_valid && full;
  assign pop   = bus.out_ready && !empty;

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rd_ptr].data;
  assign bus.out_ts    = mem[rd_ptr].ts;
  assign bus.level     = level_q;
  assign bus.drop_cnt  = drop_q;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts      <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      drop_q  <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
      if (drop && drop_q != DROP_MAX) drop_q <= drop_q + 16'd1;
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by level, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{ts: ts, data: bus.in_data};
  end
endmodule

// File: tb/tb_dpi_sample_queue.sv
// Self-checking bench for dpi_sample_queue against a queue-based reference model.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_dpi_sample_queue;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 16;
  localparam int AW     = $clog2(DEPTH);

  logic clk;
  logic rst;

  dpi_sample_queue_if #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) bus ();

  dpi_sample_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: queue of {ts, data}, free-running timestamp, saturating drop count.
  logic [TS_W+DATA_W-1:0] mq[$];
  logic [TS_W-1:0]        mts;
  int                     mdrop;
  int                     tests;
  int                     fails;

  function automatic logic [TS_W-1:0] head_ts();
    logic [TS_W+DATA_W-1:0] e;
    e = mq[0];
    return e[TS_W+DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] head_data();
    logic [TS_W+DATA_W-1:0] e;
    e = mq[0];
    return e[DATA_W-1:0];
  endfunction

  function automatic void model_reset();
    mq.delete();
    mts   = '0;
    mdrop = 0;
  endfunction

  // Called just after a falling edge: drive one cycle, let the rising edge act, update the model.
  task automatic drive_cycle(input logic iv, input logic [DATA_W-1:0] id, input logic ordy);
    bit do_push, do_pop;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    do_push = iv && (mq.size() < DEPTH);
    do_pop  = ordy && (mq.size() > 0);
    @(posedge clk);
    if (do_pop) mq.delete(0);
    if (do_push) mq.push_back({mts, id});
    else if (iv && mdrop < 65535) mdrop++;
    mts = mts + TS_W'(1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    tests++; if (bus.level !== '0) begin fails++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
    tests++; if (bus.drop_cnt !== 16'd0) begin fails++; $display("FAIL reset_drop_cnt: got %0d expected 0", bus.drop_cnt); end
    drive_cycle(1'b1, 32'h1234, 1'b0);
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL first_valid: got %b expected 1", bus.out_valid); end
    tests++; if (bus.out_ts !== 16'd0) begin fails++; $display("FAIL first_ts: got %0d expected 0", bus.out_ts); end
    tests++; if (bus.out_data !== 32'h1234) begin fails++; $display("FAIL first_data: got %h expected 00001234", bus.out_data); end
    drive_cycle(1'b0, '0, 1'b1);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL first_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_ordering();
    logic [TS_W-1:0] t0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, DATA_W'(32'hA0 + i), 1'b0);
      tests++; if (bus.level !== (AW+1)'(i + 1)) begin fails++; $display("FAIL order_fill_level: got %0d expected %0d", bus.level, i + 1); end
    end
    t0 = head_ts();
    for (int i = 0; i < 5; i++) begin
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL order_valid: got %b expected 1", bus.out_valid); end
      tests++; if (bus.out_data !== DATA_W'(32'hA0 + i)) begin fails++; $display("FAIL order_data: got %h expected %h", bus.out_data, 32'hA0 + i); end
      tests++; if (bus.out_ts !== TS_W'(t0 + TS_W'(i))) begin fails++; $display("FAIL order_ts: got %0d expected %0d", bus.out_ts, t0 + TS_W'(i)); end
      drive_cycle(1'b0, '0, 1'b1);
    end
    tests++; if (bus.level !== '0) begin fails++; $display("FAIL order_final_level: got %0d expected 0", bus.level); end
  endtask

  task automatic test_overflow();
    int drop0;
    drop0 = mdrop;
    for (int i = 0; i < 11; i++) begin
      tests++; if (bus.in_ready !== (i < DEPTH)) begin fails++; $display("FAIL ovf_in_ready[%0d]: got %b expected %b", i, bus.in_ready, i < DEPTH); end
      drive_cycle(1'b1, DATA_W'(32'hB0 + i), 1'b0);
    end
    tests++; if (bus.level !== (AW+1)'(DEPTH)) begin fails++; $display("FAIL ovf_level: got %0d expected %0d", bus.level, DEPTH); end
    tests++; if (bus.drop_cnt !== 16'(drop0 + 3)) begin fails++; $display("FAIL ovf_drop: got %0d expected %0d", bus.drop_cnt, drop0 + 3); end
    // Full with a simultaneous pop: the offered word is still dropped.
    drive_cycle(1'b1, 32'hEE, 1'b1);
    tests++; if (bus.drop_cnt !== 16'(drop0 + 4)) begin fails++; $display("FAIL fullpop_drop: got %0d expected %0d", bus.drop_cnt, drop0 + 4); end
    tests++; if (bus.level !== (AW+1)'(DEPTH - 1)) begin fails++; $display("FAIL fullpop_level: got %0d expected %0d", bus.level, DEPTH - 1); end
    for (int i = 1; i < DEPTH; i++) begin
      tests++; if (bus.out_data !== DATA_W'(32'hB0 + i)) begin fails++; $display("FAIL ovf_drain_data: got %h expected %h", bus.out_data, 32'hB0 + i); end
      drive_cycle(1'b0, '0, 1'b1);
    end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL ovf_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] next_exp;
    int got;
    int drop0;
    drop0    = mdrop;
    next_exp = 32'h100;
    got      = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) begin
        tests++; if (bus.out_data !== next_exp) begin fails++; $display("FAIL stream_data: got %h expected %h", bus.out_data, next_exp); end
        next_exp++;
        got++;
      end
      drive_cycle(1'b1, DATA_W'(32'h100 + i), 1'b1);
      tests++; if (bus.level !== (AW+1)'(1)) begin fails++; $display("FAIL stream_level[%0d]: got %0d expected 1", i, bus.level); end
    end
    tests++; if (bus.out_data !== next_exp) begin fails++; $display("FAIL stream_last: got %h expected %h", bus.out_data, next_exp); end
    got++;
    drive_cycle(1'b0, '0, 1'b1);
    tests++; if (got != 40) begin fails++; $display("FAIL stream_count: got %0d expected 40", got); end
    tests++; if (bus.drop_cnt !== 16'(drop0)) begin fails++; $display("FAIL stream_drop: got %0d expected %0d", bus.drop_cnt, drop0); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stream_empty: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic iv, ordy;
    for (int i = 0; i < 400; i++) begin
      tests++; if (bus.out_valid !== (mq.size() != 0)) begin fails++; $display("FAIL rnd_out_valid[%0d]: got %b expected %b", i, bus.out_valid, mq.size() != 0); end
      tests++; if (bus.in_ready !== (mq.size() != DEPTH)) begin fails++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, bus.in_ready, mq.size() != DEPTH); end
      tests++; if (bus.level !== (AW+1)'(mq.size())) begin fails++; $display("FAIL rnd_level[%0d]: got %0d expected %0d", i, bus.level, mq.size()); end
      tests++; if (bus.drop_cnt !== 16'(mdrop)) begin fails++; $display("FAIL rnd_drop[%0d]: got %0d expected %0d", i, bus.drop_cnt, mdrop); end
      if (mq.size() != 0) begin
        tests++; if (bus.out_data !== head_data()) begin fails++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, bus.out_data, head_data()); end
        tests++; if (bus.out_ts !== head_ts()) begin fails++; $display("FAIL rnd_ts[%0d]: got %0d expected %0d", i, bus.out_ts, head_ts()); end
      end
      // Alternate phases biased toward filling and toward draining.
      if ((i / 50) % 2 == 0) begin
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 2) == 0);
      end else begin
        iv   = ($urandom_range(0, 2) == 0);
        ordy = ($urandom_range(0, 3) != 0);
      end
      drive_cycle(iv, DATA_W'($urandom), ordy);
    end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, DATA_W'($urandom), 1'b0);
    tests++; if (bus.level !== (AW+1)'(5)) begin fails++; $display("FAIL midrst_fill: got %0d expected 5", bus.level); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b expected 0", bus.out_valid); end
    tests++; if (bus.level !== '0) begin fails++; $display("FAIL midrst_level: got %0d expected 0", bus.level); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(1'b1, 32'h55, 1'b0);
    tests++; if (bus.out_data !== 32'h55) begin fails++; $display("FAIL midrst_first: got %h expected 00000055", bus.out_data); end
    tests++; if (bus.out_ts !== 16'd0) begin fails++; $display("FAIL midrst_ts: got %0d expected 0", bus.out_ts); end
    tests++; if (bus.level !== (AW+1)'(1)) begin fails++; $display("FAIL midrst_level1: got %0d expected 1", bus.level); end
    drive_cycle(1'b0, '0, 1'b1);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_drain: got %b expected 0", bus.out_valid); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    test_reset();
    test_ordering();
    test_overflow();
    test_streaming();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
